// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame path.
//   SAMPLE_W      : sample width, signed two's complement
//   SAMPLE_MAX/MIN: saturation limits for one sample
//   state_e       : frame sequencer states
//   sat_add       : saturating add of two samples, widened internally to SAMPLE_W+2 bits
package audio_pkg;

  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned ACC_W       = SAMPLE_W + 2;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam acc_t    ACC_MAX    = {2'b00, SAMPLE_MAX};
  localparam acc_t    ACC_MIN    = {2'b11, SAMPLE_MIN};

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StFetch,
    StWaitOut,
    StWrite
  } state_e;

  // Operands are sign-extended by two bits so the raw sum can never wrap
  // before it is clamped back into sample range.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    acc_t sum;
    sum = {{2{a[SAMPLE_W-1]}}, a} + {{2{b[SAMPLE_W-1]}}, b};
    if (sum > ACC_MAX) begin
      return SAMPLE_MAX;
    end else if (sum < ACC_MIN) begin
      return SAMPLE_MIN;
    end
    return sum[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/voice_fetch_timer.sv
// Timeout counter for one voice fetch.
//   i_clk     : clock
//   i_reset   : synchronous active-high reset
//   i_run     : high while a fetch is outstanding; low clears the count to 0
//   o_expired : high in the TIMEOUT_CYC-th consecutive cycle of i_run
module voice_fetch_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // The count is 0 in the first fetch cycle, so expiry lands on cycle TIMEOUT_CYC.
  assign o_expired = i_run && (r_count == LAST);

endmodule

// File: rtl/voice_frame_scheduler.sv
// Per-audio-frame sequencer between the voice generators and the codec FIFOs.
// Each frame polls the unmasked voices in index order, sums their samples with
// per-add saturation, optionally mixes in the codec input, and pushes one frame.
//   i_clock_50 / i_reset          : clock, synchronous active-high reset
//   i_enable                      : start new frames while high
//   i_voice_mask                  : participating voices, latched at frame start
//   o_voice_req / i_voice_valid   : one-hot request / completion per voice
//   i_voice_sample                : flattened samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   i_mic_enable                  : mix codec input into the output frame
//   i_audio_in_available          : codec input FIFO non-empty
//   i_left/right_channel_audio_in : codec input samples
//   o_read_audio_in               : one-cycle pop of codec input FIFO
//   i_audio_out_allowed           : codec output FIFO has room
//   o_write_audio_out             : one-cycle push of output frame
//   o_left/right_channel_audio_out: registered output samples
//   o_frame_count                 : frames written, wraps
//   o_timeout_err                 : sticky per-voice timeout flags
module voice_frame_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                           i_clock_50,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic [NUM_VOICES-1:0]          i_voice_mask,
  output logic [NUM_VOICES-1:0]          o_voice_req,
  input  logic [NUM_VOICES-1:0]          i_voice_valid,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] i_voice_sample,
  input  logic                           i_mic_enable,
  input  logic                           i_audio_in_available,
  input  logic [SAMPLE_W-1:0]            i_left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]            i_right_channel_audio_in,
  output logic                           o_read_audio_in,
  input  logic                           i_audio_out_allowed,
  output logic                           o_write_audio_out,
  output logic [SAMPLE_W-1:0]            o_left_channel_audio_out,
  output logic [SAMPLE_W-1:0]            o_right_channel_audio_out,
  output logic [FRAME_CNT_W-1:0]         o_frame_count,
  output logic [NUM_VOICES-1:0]          o_timeout_err
);

  // Wide enough to hold NUM_VOICES, the scan start after the last voice.
  localparam int unsigned IDX_W = $clog2(NUM_VOICES + 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [NUM_VOICES-1:0]  r_mask;
  logic [IDX_W-1:0]       r_idx;
  sample_t                r_acc;
  sample_t                r_left;
  sample_t                r_right;
  logic                   r_mic_used;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic [NUM_VOICES-1:0]  r_timeout_err;

  logic [NUM_VOICES-1:0]  w_scan_mask;
  logic [IDX_W-1:0]       w_scan_start;
  logic                   w_scan_found;
  logic [IDX_W-1:0]       w_scan_idx;
  sample_t                w_cur_sample;
  logic                   w_cur_valid;
  logic [NUM_VOICES-1:0]  w_cur_onehot;
  logic                   w_fetch_active;
  logic                   w_fetch_expired;
  logic                   w_mic_take;
  sample_t                w_left_term;
  sample_t                w_right_term;

  // Priority scan for the lowest set mask bit at or above the start index.
  // In IDLE it scans the live mask from 0 so the first fetch begins without
  // a separate scan cycle; after a fetch it resumes just past the last voice.
  always_comb begin
    w_scan_mask  = (r_state == StIdle) ? i_voice_mask : r_mask;
    w_scan_start = (r_state == StIdle) ? '0 : (r_idx + IDX_W'(1));
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (w_scan_mask[i] && (IDX_W'(i) >= w_scan_start)) begin
        w_scan_found = 1'b1;
        w_scan_idx   = IDX_W'(i);
      end
    end
  end

  // Current voice selection; valid bits of other voices are never looked at.
  always_comb begin
    w_cur_sample = '0;
    w_cur_valid  = 1'b0;
    w_cur_onehot = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_sample    = i_voice_sample[i*SAMPLE_W +: SAMPLE_W];
        w_cur_valid     = i_voice_valid[i];
        w_cur_onehot[i] = 1'b1;
      end
    end
  end

  assign w_fetch_active = (r_state == StFetch);

  voice_fetch_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fetch_timer (
    .i_clk    (i_clock_50),
    .i_reset  (i_reset),
    .i_run    (w_fetch_active),
    .o_expired(w_fetch_expired)
  );

  assign w_mic_take   = i_mic_enable & i_audio_in_available;
  assign w_left_term  = w_mic_take ? i_left_channel_audio_in : '0;
  assign w_right_term = w_mic_take ? i_right_channel_audio_in : '0;

  // State register.
  always_ff @(posedge i_clock_50) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state_next = w_scan_found ? StFetch : StWaitOut;
        end
      end
      StScan: begin
        w_state_next = w_scan_found ? StFetch : StWaitOut;
      end
      StFetch: begin
        if (w_cur_valid || w_fetch_expired) begin
          w_state_next = StScan;
        end
      end
      StWaitOut: begin
        if (i_audio_out_allowed) begin
          w_state_next = StWrite;
        end
      end
      StWrite: begin
        // Losing the slot between latch and push forces a fresh mix.
        w_state_next = i_audio_out_allowed ? StIdle : StWaitOut;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    o_voice_req       = w_fetch_active ? w_cur_onehot : '0;
    o_write_audio_out = (r_state == StWrite) && i_audio_out_allowed;
    o_read_audio_in   = (r_state == StWrite) && i_audio_out_allowed && r_mic_used;
  end

  // Datapath registers.
  always_ff @(posedge i_clock_50) begin
    if (i_reset) begin
      r_mask        <= '0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_left        <= '0;
      r_right       <= '0;
      r_mic_used    <= 1'b0;
      r_frame_count <= '0;
      r_timeout_err <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_enable) begin
            r_mask <= i_voice_mask;
            r_acc  <= '0;
            r_idx  <= w_scan_idx;
          end
        end
        StScan: begin
          if (w_scan_found) begin
            r_idx <= w_scan_idx;
          end
        end
        StFetch: begin
          // A handshake in the expiry cycle still counts as a real sample.
          if (w_cur_valid) begin
            r_acc <= sat_add(r_acc, w_cur_sample);
          end else if (w_fetch_expired) begin
            r_timeout_err <= r_timeout_err | w_cur_onehot;
          end
        end
        StWaitOut: begin
          if (i_audio_out_allowed) begin
            r_left     <= sat_add(r_acc, w_left_term);
            r_right    <= sat_add(r_acc, w_right_term);
            r_mic_used <= w_mic_take;
          end
        end
        StWrite: begin
          if (i_audio_out_allowed) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_left_channel_audio_out  = r_left;
  assign o_right_channel_audio_out = r_right;
  assign o_frame_count             = r_frame_count;
  assign o_timeout_err             = r_timeout_err;

endmodule
